// File: rtl/mriscv_irq_pkg.sv
// Shared definitions for the interrupt controller slice.
// Contents: RETIRQ opcode encoding, interrupt id width, controller state enum.
package mriscv_irq_pkg;

   // Decoded opcode of the return-from-interrupt instruction
   localparam logic [11:0] RETIRQ_OP = 12'b0011_1001_1000;

   // Width of an interrupt line id (covers up to 32 lines)
   localparam int IRQ_ID_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SVC  = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Core <-> interrupt controller redirect interface.
// Core side drives the commit strobe, decoded opcode and its next PC;
// controller side returns the redirect request, vector and saved return PC.
//   enable_pc  core commits its next PC this cycle
//   opcode     decoded opcode of the current instruction
//   pc_next    next PC without the interrupt redirect
//   irr        redirect request
//   irr_dest   redirect target (vector address)
//   irr_ret    saved return PC
interface irq_ctrl_if;
   logic        enable_pc;
   logic [11:0] opcode;
   logic [31:0] pc_next;
   logic        irr;
   logic [31:0] irr_dest;
   logic [31:0] irr_ret;

   modport master (
      output enable_pc, opcode, pc_next,
      input  irr, irr_dest, irr_ret
   );

   modport slave (
      input  enable_pc, opcode, pc_next,
      output irr, irr_dest, irr_ret
   );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder.
//   req    request vector (N_IRQ bits)
//   valid  at least one request bit is set
//   id     index of the lowest set request bit (0 when none)
module irq_prio_enc
   import mriscv_irq_pkg::*;
#(
   parameter int N_IRQ = 8
) (
   input  logic [N_IRQ-1:0]    req,
   output logic                valid,
   output logic [IRQ_ID_W-1:0] id
);

   // Scan from the top down so the lowest set index is the last one written
   always_comb begin
      valid = 1'b0;
      id    = {IRQ_ID_W{1'b0}};
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = IRQ_ID_W'(i);
         end else begin
            valid = valid;
            id    = id;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Single-level interrupt controller driving the core's redirect interface.
// Latches rising edges of irq_in as pending, picks the lowest-index enabled
// pending line, redirects the core to its vector, saves the return PC and
// waits for RETIRQ before taking the next interrupt.
//   clk, rst     clock; synchronous active-low reset
//   irq_in       interrupt level inputs (rising edge = request)
//   mask_wr      enable-mask write strobe, mask_wdata new mask
//   core         redirect interface (slave side)
//   irq_active   handler in service
//   irq_id       id of the line being requested or serviced
//   irq_pending  latched pending bits, independent of the mask
module irq_ctrl
   import mriscv_irq_pkg::*;
#(
   parameter int          N_IRQ      = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IRQ-1:0]    irq_in,
   input  logic                mask_wr,
   input  logic [N_IRQ-1:0]    mask_wdata,
   irq_ctrl_if.slave           core,
   output logic                irq_active,
   output logic [IRQ_ID_W-1:0] irq_id,
   output logic [N_IRQ-1:0]    irq_pending
);

   irq_state_e          state_r;
   irq_state_e          state_s;
   logic [N_IRQ-1:0]    irq_q_r;
   logic [N_IRQ-1:0]    pending_r;
   logic [N_IRQ-1:0]    mask_r;
   logic [N_IRQ-1:0]    rise_s;
   logic [N_IRQ-1:0]    clr_s;
   logic                win_valid_s;
   logic [IRQ_ID_W-1:0] win_id_s;
   logic [31:0]         vec_s;
   logic                load_s;
   logic                commit_s;
   logic [IRQ_ID_W-1:0] irq_id_r;
   logic [31:0]         irr_dest_r;
   logic [31:0]         irr_ret_r;
   logic                irr_r;
   logic                active_r;

   assign rise_s = irq_in & ~irq_q_r;

   irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
      .req   (pending_r & mask_r),
      .valid (win_valid_s),
      .id    (win_id_s)
   );

   // Vector arithmetic wraps modulo 2^32
   assign vec_s = VEC_BASE + ({{(32-IRQ_ID_W){1'b0}}, win_id_s} * VEC_STRIDE);

   // Next-state decode; commit marks the cycle the redirect is taken
   always_comb begin
      state_s  = state_r;
      commit_s = 1'b0;
      load_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_valid_s) begin
               state_s = REQ;
               load_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (core.enable_pc) begin
               state_s  = SVC;
               commit_s = 1'b1;
            end else begin
               state_s = REQ;
            end
         end
         SVC: begin
            if (core.enable_pc && (core.opcode == RETIRQ_OP)) begin
               state_s = IDLE;
            end else begin
               state_s = SVC;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // One-hot clear of the line being taken; a same-cycle rise re-sets it below
   always_comb begin
      clr_s = {N_IRQ{1'b0}};
      for (int i = 0; i < N_IRQ; i++) begin
         clr_s[i] = commit_s && (irq_id_r == IRQ_ID_W'(i));
      end
   end

   // State, edge detector, pending and mask registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         irq_q_r   <= {N_IRQ{1'b0}};
         pending_r <= {N_IRQ{1'b0}};
         mask_r    <= {N_IRQ{1'b0}};
      end else begin
         state_r   <= state_s;
         irq_q_r   <= irq_in;
         pending_r <= (pending_r & ~clr_s) | rise_s;
         if (mask_wr) begin
            mask_r <= mask_wdata;
         end
      end
   end

   // Registered redirect outputs; irr/irq_active follow the next state
   always_ff @(posedge clk) begin
      if (!rst) begin
         irq_id_r   <= {IRQ_ID_W{1'b0}};
         irr_dest_r <= 32'h0;
         irr_ret_r  <= 32'h0;
         irr_r      <= 1'b0;
         active_r   <= 1'b0;
      end else begin
         if (load_s) begin
            irq_id_r   <= win_id_s;
            irr_dest_r <= vec_s;
         end
         if (commit_s) begin
            irr_ret_r <= core.pc_next;
         end
         irr_r    <= (state_s == REQ);
         active_r <= (state_s == SVC);
      end
   end

   assign core.irr      = irr_r;
   assign core.irr_dest = irr_dest_r;
   assign core.irr_ret  = irr_ret_r;
   assign irq_active    = active_r;
   assign irq_id        = irq_id_r;
   assign irq_pending   = pending_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_irq_ctrl;

   localparam logic [11:0] OP_RET = 12'b001110011000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_wr;
   logic [7:0] mask_wdata;
   logic       irq_active;
   logic [4:0] irq_id;
   logic [7:0] irq_pending;

   int checks = 0;
   int errors = 0;

   irq_ctrl_if core_if ();

   irq_ctrl #(.N_IRQ(8), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'd4)) dut (
      .clk         (clk),
      .rst         (rst),
      .irq_in      (irq_in),
      .mask_wr     (mask_wr),
      .mask_wdata  (mask_wdata),
      .core        (core_if),
      .irq_active  (irq_active),
      .irq_id      (irq_id),
      .irq_pending (irq_pending)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase 0 = nothing taken, 1 = redirect offered, 2 = in handler
   logic [7:0]  m_pend, m_mask, m_prev;
   int          m_phase, m_id;
   logic [31:0] m_dest, m_ret;

   task automatic model_step();
      logic [7:0] rise, elig, low, nxt;
      if (!rst) begin
         m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
         m_phase = 0; m_id = 0; m_dest = 32'h0; m_ret = 32'h0;
      end else begin
         rise = irq_in & ~m_prev;
         nxt  = m_pend | rise;
         elig = m_pend & m_mask;
         if (m_phase == 0 && elig != 8'h00) begin
            low     = elig & (~elig + 8'd1);
            m_id    = $clog2(low);
            m_dest  = 32'h100 + 32'(m_id) * 32'd4;
            m_phase = 1;
         end else if (m_phase == 1 && core_if.enable_pc) begin
            m_ret   = core_if.pc_next;
            nxt     = (m_pend & ~(8'd1 << m_id)) | rise;
            m_phase = 2;
         end else if (m_phase == 2 && core_if.enable_pc && core_if.opcode == OP_RET) begin
            m_phase = 0;
         end
         m_pend = nxt;
         if (mask_wr) m_mask = mask_wdata;
         m_prev = irq_in;
      end
   endtask

   // Advance one clock; outputs are observed at the following negedge
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0; irq_in = 8'h00; mask_wr = 1'b0; mask_wdata = 8'h00;
      core_if.enable_pc = 1'b0; core_if.opcode = 12'h000; core_if.pc_next = 32'h0;
      tick();
      rst = 1'b1;
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_wr = 1'b1; mask_wdata = m;
      tick();
      mask_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; irq_in = 8'hFF; mask_wr = 1'b1; mask_wdata = 8'hFF;
      core_if.enable_pc = 1'b1; core_if.opcode = OP_RET; core_if.pc_next = 32'hDEAD_BEEF;
      tick(); tick(); tick();
      checks++;
      if ({core_if.irr, irq_active, irq_id, irq_pending} !== 15'h0) begin
         errors++;
         $display("FAIL reset_ctrl got irr=%b act=%b id=%0d pend=%h want all 0",
                  core_if.irr, irq_active, irq_id, irq_pending);
      end
      checks++;
      if ({core_if.irr_dest, core_if.irr_ret} !== 64'h0) begin
         errors++;
         $display("FAIL reset_pc got dest=%h ret=%h want 0", core_if.irr_dest, core_if.irr_ret);
      end
      rst = 1'b1; irq_in = 8'h00; mask_wr = 1'b0;
      core_if.enable_pc = 1'b0; core_if.opcode = 12'h000;
      tick();
      checks++;
      if ({core_if.irr, irq_pending} !== 9'h0) begin
         errors++;
         $display("FAIL reset_release got irr=%b pend=%h want 0", core_if.irr, irq_pending);
      end
   endtask

   task automatic test_single();
      do_reset();
      write_mask(8'h08);
      irq_in = 8'h08; core_if.enable_pc = 1'b1; core_if.pc_next = 32'h40;
      tick();
      checks++;
      if ({core_if.irr, irq_pending} !== {1'b0, 8'h08}) begin
         errors++;
         $display("FAIL single_pend got irr=%b pend=%h want 0/08", core_if.irr, irq_pending);
      end
      tick();
      checks++;
      if ({core_if.irr, irq_id, core_if.irr_dest} !== {1'b1, 5'd3, 32'h10C}) begin
         errors++;
         $display("FAIL single_req got irr=%b id=%0d dest=%h want 1/3/10c",
                  core_if.irr, irq_id, core_if.irr_dest);
      end
      tick();
      checks++;
      if ({core_if.irr, irq_active, core_if.irr_ret, irq_pending} !== {1'b0, 1'b1, 32'h40, 8'h00}) begin
         errors++;
         $display("FAIL single_svc got irr=%b act=%b ret=%h pend=%h want 0/1/40/00",
                  core_if.irr, irq_active, core_if.irr_ret, irq_pending);
      end
      core_if.opcode = OP_RET;
      tick();
      checks++;
      if ({core_if.irr, irq_active, core_if.irr_ret} !== {1'b0, 1'b0, 32'h40}) begin
         errors++;
         $display("FAIL single_ret got irr=%b act=%b ret=%h want 0/0/40",
                  core_if.irr, irq_active, core_if.irr_ret);
      end
      core_if.opcode = 12'h000; core_if.enable_pc = 1'b0; irq_in = 8'h00;
   endtask

   task automatic test_priority_chain();
      do_reset();
      write_mask(8'hFF);
      irq_in = 8'h24;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if ({core_if.irr, irq_id, core_if.irr_dest} !== {1'b1, 5'd2, 32'h108}) begin
            errors++;
            $display("FAIL prio_hold%0d got irr=%b id=%0d dest=%h want 1/2/108",
                     k, core_if.irr, irq_id, core_if.irr_dest);
         end
      end
      core_if.enable_pc = 1'b1; core_if.pc_next = 32'h200;
      tick();
      checks++;
      if ({irq_active, irq_pending, core_if.irr_ret} !== {1'b1, 8'h20, 32'h200}) begin
         errors++;
         $display("FAIL prio_commit got act=%b pend=%h ret=%h want 1/20/200",
                  irq_active, irq_pending, core_if.irr_ret);
      end
      core_if.enable_pc = 1'b0; irq_in = 8'h25;
      tick(); tick();
      checks++;
      if ({core_if.irr, irq_active, irq_pending} !== {1'b0, 1'b1, 8'h21}) begin
         errors++;
         $display("FAIL nest_pend got irr=%b act=%b pend=%h want 0/1/21",
                  core_if.irr, irq_active, irq_pending);
      end
      core_if.enable_pc = 1'b1; core_if.opcode = OP_RET;
      tick();
      checks++;
      if ({core_if.irr, irq_active} !== 2'b00) begin
         errors++;
         $display("FAIL chain_idle got irr=%b act=%b want 0/0", core_if.irr, irq_active);
      end
      core_if.enable_pc = 1'b0; core_if.opcode = 12'h000;
      tick();
      checks++;
      if ({core_if.irr, irq_id, core_if.irr_dest} !== {1'b1, 5'd0, 32'h100}) begin
         errors++;
         $display("FAIL chain_req got irr=%b id=%0d dest=%h want 1/0/100",
                  core_if.irr, irq_id, core_if.irr_dest);
      end
   endtask

   task automatic test_mask();
      do_reset();
      irq_in = 8'h80;
      tick(); tick(); tick();
      checks++;
      if ({core_if.irr, irq_pending} !== {1'b0, 8'h80}) begin
         errors++;
         $display("FAIL mask_block got irr=%b pend=%h want 0/80", core_if.irr, irq_pending);
      end
      write_mask(8'h80);
      checks++;
      if (core_if.irr !== 1'b0) begin
         errors++;
         $display("FAIL mask_early got irr=%b want 0", core_if.irr);
      end
      tick();
      checks++;
      if ({core_if.irr, irq_id, core_if.irr_dest} !== {1'b1, 5'd7, 32'h11C}) begin
         errors++;
         $display("FAIL mask_req got irr=%b id=%0d dest=%h want 1/7/11c",
                  core_if.irr, irq_id, core_if.irr_dest);
      end
   endtask

   task automatic test_edge_cases();
      do_reset();
      write_mask(8'hFF);
      irq_in = 8'h02;
      tick(); tick();
      core_if.enable_pc = 1'b1; core_if.pc_next = 32'h555;
      tick();
      core_if.opcode = OP_RET;
      tick();
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({core_if.irr, irq_active, core_if.irr_ret} !== {1'b0, 1'b0, 32'h555}) begin
            errors++;
            $display("FAIL retirq_idle%0d got irr=%b act=%b ret=%h want 0/0/555",
                     k, core_if.irr, irq_active, core_if.irr_ret);
         end
      end
      core_if.enable_pc = 1'b0; core_if.opcode = 12'h000; irq_in = 8'h12;
      tick(); tick();
      core_if.enable_pc = 1'b1; core_if.pc_next = 32'h777;
      tick();
      checks++;
      if ({irq_active, core_if.irr_ret} !== {1'b1, 32'h777}) begin
         errors++;
         $display("FAIL svc_entry got act=%b ret=%h want 1/777", irq_active, core_if.irr_ret);
      end
      core_if.enable_pc = 1'b0; rst = 1'b0;
      tick();
      checks++;
      if ({core_if.irr, irq_active, core_if.irr_ret, irq_pending} !== 42'h0) begin
         errors++;
         $display("FAIL svc_reset got irr=%b act=%b ret=%h pend=%h want 0",
                  core_if.irr, irq_active, core_if.irr_ret, irq_pending);
      end
      rst = 1'b1; irq_in = 8'h00;
      write_mask(8'hFF);
      irq_in = 8'h02;
      tick();
      irq_in = 8'h00;
      tick();
      checks++;
      if ({core_if.irr, irq_id} !== {1'b1, 5'd1}) begin
         errors++;
         $display("FAIL setwins_req got irr=%b id=%0d want 1/1", core_if.irr, irq_id);
      end
      irq_in = 8'h02; core_if.enable_pc = 1'b1;
      tick();
      checks++;
      if ({irq_active, irq_pending} !== {1'b1, 8'h02}) begin
         errors++;
         $display("FAIL setwins_pend got act=%b pend=%h want 1/02", irq_active, irq_pending);
      end
   endtask

   task automatic test_random();
      logic [78:0] got, want;
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         rst = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 8'($urandom);
         mask_wr = ($urandom_range(0, 7) == 0);
         mask_wdata = 8'($urandom);
         core_if.enable_pc = ($urandom_range(0, 1) == 1);
         core_if.opcode = ($urandom_range(0, 2) == 0) ? OP_RET : 12'($urandom);
         core_if.pc_next = $urandom;
         tick();
         got  = {core_if.irr, irq_active, irq_id, irq_pending, core_if.irr_dest, core_if.irr_ret};
         want = {(m_phase == 1), (m_phase == 2), 5'(m_id), m_pend, m_dest, m_ret};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL random_cyc%0d got %h want %h", n, got, want);
         end
      end
   endtask

   initial begin
      rst = 1'b0; irq_in = 8'h00; mask_wr = 1'b0; mask_wdata = 8'h00;
      core_if.enable_pc = 1'b0; core_if.opcode = 12'h000; core_if.pc_next = 32'h0;
      @(negedge clk);
      test_reset();
      test_single();
      test_priority_chain();
      test_mask();
      test_edge_cases();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
